// File: rtl/axi4_lite_rif_bridge_if.sv
// Purpose: AXI4-Lite slave channels plus the per-port register-interface (RIF) request/ack bus.
// Latency: none (wiring only).
// Backpressure: AXI valid/ready pairs towards the interconnect, per-port req/ack towards the RIF targets.
interface axi4_lite_rif_bridge_if #(
  parameter int ID_W      = 1,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int NUM_PORTS = 4
);
  localparam int STRB_W = DATA_W / 8;

  logic [ID_W-1:0]             awid;
  logic [ADDR_W-1:0]           awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  logic [DATA_W-1:0]           wdata;
  logic [STRB_W-1:0]           wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [ID_W-1:0]             bid;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [ID_W-1:0]             arid;
  logic [ADDR_W-1:0]           araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  logic [ID_W-1:0]             rid;
  logic [DATA_W-1:0]           rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;
  logic [ADDR_W-1:0]           rif_waddr;
  logic [DATA_W-1:0]           rif_wdata;
  logic [STRB_W-1:0]           rif_wstrb;
  logic [NUM_PORTS-1:0]        rif_wr_req;
  logic [NUM_PORTS-1:0]        rif_wack;
  logic [NUM_PORTS-1:0]        rif_werr;
  logic [ADDR_W-1:0]           rif_raddr;
  logic [NUM_PORTS-1:0]        rif_rd_req;
  logic [NUM_PORTS-1:0]        rif_rack;
  logic [NUM_PORTS-1:0]        rif_rerr;
  logic [NUM_PORTS*DATA_W-1:0] rif_rdata;

  // Bridge side: AXI slave, RIF master.
  modport slave (
    input  awid, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  arid, araddr, arprot, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rvalid,
    output rif_waddr, rif_wdata, rif_wstrb, rif_wr_req, rif_raddr, rif_rd_req,
    input  rif_wack, rif_werr, rif_rack, rif_rerr, rif_rdata
  );

  // Environment side: AXI master plus the RIF targets.
  modport master (
    output awid, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output arid, araddr, arprot, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rvalid,
    input  rif_waddr, rif_wdata, rif_wstrb, rif_wr_req, rif_raddr, rif_rd_req,
    output rif_wack, rif_werr, rif_rack, rif_rerr, rif_rdata
  );
endinterface

// File: rtl/axi4_lite_rif_bridge.sv
// Purpose: AXI4-Lite slave to NUM_PORTS RIF targets with address decode; optional REQ timeout via AXI4_LITE_RIF_BRIDGE_TIMEOUT_EN.
// Latency: AW+W (or AR) accept -> RIF req next cycle -> response the cycle after the ack (2 cycles minimum).
// Backpressure: one write and one read in flight; ready drops until the B/R response is taken, req held until ack.
module axi4_lite_rif_bridge #(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int NUM_PORTS      = 4,
  parameter int EN_SEC_MODE    = 0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                   aclk,
  input logic                   aresetn,
  axi4_lite_rif_bridge_if.slave bus
);
  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int SEL_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 0;
  localparam int SEL_WX = (SEL_W > 0) ? SEL_W : 1;

  // One-hot target select from the top address bits; all-zero means no such port (DECERR).
  function automatic logic [NUM_PORTS-1:0] decode(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [4:0]           idx;
    logic [NUM_PORTS-1:0] oh;
    idx = (SEL_W == 0) ? 5'd0 : 5'(a >> (AXI_ADDR_WIDTH - SEL_WX));
    for (int p = 0; p < NUM_PORTS; p++) oh[p] = (idx == 5'(p));
    return oh;
  endfunction

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} rstate_e;

  wstate_e                   wstate_q, wstate_d;
  logic                      aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic                      awready_q, awready_d, wready_q, wready_d;
  logic [AXI_ID_WIDTH-1:0]   bid_q, bid_d;
  logic [AXI_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                      wprot1_q, wprot1_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic [NUM_PORTS-1:0]      wsel_q, wsel_d;
  logic [1:0]                bresp_q, bresp_d;

  rstate_e                   rstate_q, rstate_d;
  logic                      arready_q, arready_d;
  logic [AXI_ID_WIDTH-1:0]   rid_q, rid_d;
  logic [AXI_ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [NUM_PORTS-1:0]      rsel_q, rsel_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [AXI_DATA_WIDTH-1:0] rd_mux;

  logic w_ack, w_err, w_tmo, r_ack, r_err, r_tmo;

  // Only acks/errors from the selected port count; the others are ignored.
  assign w_ack = |(bus.rif_wack & wsel_q);
  assign w_err = |(bus.rif_werr & wsel_q);
  assign r_ack = |(bus.rif_rack & rsel_q);
  assign r_err = |(bus.rif_rerr & rsel_q);

`ifdef AXI4_LITE_RIF_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;

  // Counters run only while in REQ, so they start at zero on every REQ entry.
  assign wcnt_d = (wstate_q == W_REQ) ? wcnt_q + CNT_W'(1) : '0;
  assign rcnt_d = (rstate_q == R_REQ) ? rcnt_q + CNT_W'(1) : '0;
  assign w_tmo  = (wcnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign r_tmo  = (rcnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait-state counters for the request timeout.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wcnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
    end
  end
`else
  logic unused_timeout;
  assign w_tmo          = 1'b0;
  assign r_tmo          = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  logic unused_prot;
  assign unused_prot = &{1'b0, bus.awprot[2], bus.awprot[0], bus.arprot[2], bus.arprot[0]};

  // Write FSM: collect AW and W in any order, issue the RIF write, hold B until taken.
  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    bid_d     = bid_q;
    waddr_d   = waddr_q;
    wprot1_d  = wprot1_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wsel_d    = wsel_q;
    bresp_d   = bresp_q;
    case (wstate_q)
      W_IDLE: begin
        if (bus.awvalid && awready_q) begin
          aw_held_d = 1'b1;
          waddr_d   = bus.awaddr;
          bid_d     = bus.awid;
          wprot1_d  = bus.awprot[1];
        end
        if (bus.wvalid && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = bus.wdata;
          wstrb_d  = bus.wstrb;
        end
        if (aw_held_d && w_held_d) begin
          wsel_d = decode(waddr_d);
          if (wsel_d == '0) begin
            bresp_d  = 2'b11;
            wstate_d = W_RESP;
          end else if (EN_SEC_MODE != 0 && !wprot1_d) begin
            bresp_d  = 2'b10;
            wstate_d = W_RESP;
          end else begin
            wstate_d = W_REQ;
          end
        end
      end
      W_REQ: begin
        if (w_ack) begin
          bresp_d  = w_err ? 2'b10 : 2'b00;
          wstate_d = W_RESP;
        end else if (w_tmo) begin
          bresp_d  = 2'b10;
          wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          wstate_d  = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    awready_d = (wstate_d == W_IDLE) && !aw_held_d;
    wready_d  = (wstate_d == W_IDLE) && !w_held_d;
  end

  // Write-side state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate_q  <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bid_q     <= '0;
      waddr_q   <= '0;
      wprot1_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wsel_q    <= '0;
      bresp_q   <= '0;
    end else begin
      wstate_q  <= wstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bid_q     <= bid_d;
      waddr_q   <= waddr_d;
      wprot1_q  <= wprot1_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wsel_q    <= wsel_d;
      bresp_q   <= bresp_d;
    end
  end

  // Read data of the selected port (AND-OR mux over the one-hot select).
  always_comb begin
    rd_mux = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rsel_q[p]) rd_mux = rd_mux | bus.rif_rdata[p*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    end
  end

  // Read FSM: accept AR, issue the RIF read, hold R until taken; data forced to 0 on any error.
  always_comb begin
    rstate_d = rstate_q;
    rid_d    = rid_q;
    raddr_d  = raddr_q;
    rsel_d   = rsel_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    case (rstate_q)
      R_IDLE: begin
        if (bus.arvalid && arready_q) begin
          rid_d   = bus.arid;
          raddr_d = bus.araddr;
          rsel_d  = decode(bus.araddr);
          rdata_d = '0;
          if (rsel_d == '0) begin
            rresp_d  = 2'b11;
            rstate_d = R_RESP;
          end else if (EN_SEC_MODE != 0 && !bus.arprot[1]) begin
            rresp_d  = 2'b10;
            rstate_d = R_RESP;
          end else begin
            rstate_d = R_REQ;
          end
        end
      end
      R_REQ: begin
        if (r_ack) begin
          rresp_d  = r_err ? 2'b10 : 2'b00;
          rdata_d  = r_err ? '0 : rd_mux;
          rstate_d = R_RESP;
        end else if (r_tmo) begin
          rresp_d  = 2'b10;
          rdata_d  = '0;
          rstate_d = R_RESP;
        end
      end
      R_RESP: begin
        if (bus.rready) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
    arready_d = (rstate_d == R_IDLE);
  end

  // Read-side state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rid_q     <= '0;
      raddr_q   <= '0;
      rsel_q    <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rsel_q    <= rsel_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.awready    = awready_q;
  assign bus.wready     = wready_q;
  assign bus.bvalid     = (wstate_q == W_RESP);
  assign bus.bid        = bid_q;
  assign bus.bresp      = bresp_q;
  assign bus.rif_wr_req = (wstate_q == W_REQ) ? wsel_q : '0;
  assign bus.rif_waddr  = waddr_q;
  assign bus.rif_wdata  = wdata_q;
  assign bus.rif_wstrb  = wstrb_q;
  assign bus.arready    = arready_q;
  assign bus.rvalid     = (rstate_q == R_RESP);
  assign bus.rid        = rid_q;
  assign bus.rresp      = rresp_q;
  assign bus.rdata      = rdata_q;
  assign bus.rif_rd_req = (rstate_q == R_REQ) ? rsel_q : '0;
  assign bus.rif_raddr  = raddr_q;
endmodule
